// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Package     : lc3b_types
// Description : Shared LC-3b types: memory-operation encoding, byte-enable
//               constants and small decode helpers for the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    // Memory operation carried in the EX/MEM register; codes 6 and 7 unused
    typedef enum logic [2:0] {
        LD  = 3'd0,
        LDB = 3'd1,
        LDI = 3'd2,
        ST  = 3'd3,
        STB = 3'd4,
        STI = 3'd5
    } lc3b_memop;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    // True for the six defined encodings
    function automatic logic memop_valid(input logic [2:0] op);
        return (op <= 3'd5);
    endfunction

    function automatic logic memop_is_load(input lc3b_memop op);
        return (op == LD) || (op == LDB) || (op == LDI);
    endfunction

    function automatic logic memop_is_indirect(input lc3b_memop op);
        return (op == LDI) || (op == STI);
    endfunction

endpackage : lc3b_types
`default_nettype wire

// File: rtl/mem_stage_access_ctrl_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_lane
// Description : Combinational byte-lane steering. Store side replicates the
//               source byte and picks the lane enable; load side extracts and
//               sign-extends the addressed byte.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_lane
    import lc3b_types::*;
#(
    parameter int DATA_W = 16
) (
    input  lc3b_memop         i_st_op,
    input  logic              i_st_addr0,
    input  logic [DATA_W-1:0] i_st_src,
    output logic [DATA_W-1:0] o_st_wdata,
    output logic [1:0]        o_st_be,
    input  lc3b_memop         i_ld_op,
    input  logic              i_ld_addr0,
    input  logic [DATA_W-1:0] i_ld_rdata,
    output logic [DATA_W-1:0] o_ld_result
);

    localparam int c_HALF_W = DATA_W / 2;

    logic [c_HALF_W-1:0] w_ld_byte;

    // Store steering: byte stores drive the same byte on both lanes
    always_comb begin
        o_st_wdata = i_st_src;
        o_st_be    = BE_WORD;
        if (i_st_op == STB) begin
            o_st_wdata = {2{i_st_src[c_HALF_W-1:0]}};
            o_st_be    = i_st_addr0 ? BE_HI : BE_LO;
        end
    end

    // Load extraction: odd address selects the high byte, then sign-extend
    always_comb begin
        w_ld_byte   = i_ld_addr0 ? i_ld_rdata[DATA_W-1:c_HALF_W]
                                 : i_ld_rdata[c_HALF_W-1:0];
        o_ld_result = i_ld_rdata;
        if (i_ld_op == LDB) begin
            o_ld_result = {{c_HALF_W{w_ld_byte[c_HALF_W-1]}}, w_ld_byte};
        end
    end

endmodule : mem_byte_lane
`default_nettype wire

// File: rtl/mem_stage_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_access_ctrl
// Description : MEM-stage data-cache initiator. Captures the EX/MEM request,
//               runs the optional pointer read for LDI/STI, performs the
//               final access with byte steering, stalls the pipeline until
//               completion and returns the load result with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_access_ctrl
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] dcache_address,
    output logic              dcache_read,
    output logic              dcache_write,
    output logic [DATA_W-1:0] dcache_wdata,
    output logic [1:0]        dcache_byte_enable,
    input  logic [DATA_W-1:0] dcache_rdata,
    input  logic              dcache_resp,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PTR  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state,     w_state_nxt;
    lc3b_memop         r_op,        w_op_nxt;
    logic              r_addr_lsb,  w_addr_lsb_nxt;
    logic [DATA_W-1:0] r_wdata,     w_wdata_nxt;
    logic [ADDR_W-1:0] r_dc_addr,   w_dc_addr_nxt;
    logic              r_dc_read,   w_dc_read_nxt;
    logic              r_dc_write,  w_dc_write_nxt;
    logic [DATA_W-1:0] r_dc_wdata,  w_dc_wdata_nxt;
    logic [1:0]        r_dc_be,     w_dc_be_nxt;
    logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;

    logic              w_req_ok;
    lc3b_memop         w_req_op;
    lc3b_memop         w_acc_op;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_src;
    logic [DATA_W-1:0] w_st_wdata;
    logic [1:0]        w_st_be;
    logic [DATA_W-1:0] w_ld_result;
    logic              w_stall;
    logic              w_done;

    assign w_req_ok = req_valid && memop_valid(req_op);
    assign w_req_op = lc3b_memop'(req_op);

    // Fields of the upcoming final access: straight from the request when
    // leaving IDLE, or from the captured request plus the returned pointer
    // when leaving PTR
    always_comb begin
        w_acc_op   = r_op;
        w_acc_addr = dcache_rdata[ADDR_W-1:0];
        w_acc_src  = r_wdata;
        if (r_state == S_IDLE) begin
            w_acc_op   = w_req_op;
            w_acc_addr = req_addr;
            w_acc_src  = req_wdata;
        end
    end

    mem_byte_lane #(
        .DATA_W (DATA_W)
    ) u_byte_lane (
        .i_st_op     (w_acc_op),
        .i_st_addr0  (w_acc_addr[0]),
        .i_st_src    (w_acc_src),
        .o_st_wdata  (w_st_wdata),
        .o_st_be     (w_st_be),
        .i_ld_op     (r_op),
        .i_ld_addr0  (r_addr_lsb),
        .i_ld_rdata  (dcache_rdata),
        .o_ld_result (w_ld_result)
    );

    // Next-state, next-register and combinational output decode
    always_comb begin
        w_state_nxt    = r_state;
        w_op_nxt       = r_op;
        w_addr_lsb_nxt = r_addr_lsb;
        w_wdata_nxt    = r_wdata;
        w_dc_addr_nxt  = r_dc_addr;
        w_dc_read_nxt  = r_dc_read;
        w_dc_write_nxt = r_dc_write;
        w_dc_wdata_nxt = r_dc_wdata;
        w_dc_be_nxt    = r_dc_be;
        w_rdata_nxt    = r_rdata;
        w_stall        = 1'b0;
        w_done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_stall = w_req_ok;
                if (w_req_ok) begin
                    w_op_nxt       = w_req_op;
                    w_addr_lsb_nxt = req_addr[0];
                    w_wdata_nxt    = req_wdata;
                    if (memop_is_indirect(w_req_op)) begin
                        // Pointer fetch is always a full aligned word read
                        w_state_nxt    = S_PTR;
                        w_dc_addr_nxt  = {req_addr[ADDR_W-1:1], 1'b0};
                        w_dc_read_nxt  = 1'b1;
                        w_dc_write_nxt = 1'b0;
                        w_dc_wdata_nxt = '0;
                        w_dc_be_nxt    = BE_WORD;
                    end else begin
                        w_state_nxt    = S_DATA;
                        w_dc_addr_nxt  = {w_acc_addr[ADDR_W-1:1], 1'b0};
                        w_dc_read_nxt  = memop_is_load(w_acc_op);
                        w_dc_write_nxt = !memop_is_load(w_acc_op);
                        w_dc_wdata_nxt = memop_is_load(w_acc_op) ? '0 : w_st_wdata;
                        w_dc_be_nxt    = w_st_be;
                    end
                end
            end

            S_PTR: begin
                w_stall = 1'b1;
                if (dcache_resp) begin
                    // Pointer becomes the effective address of the final access
                    w_state_nxt    = S_DATA;
                    w_addr_lsb_nxt = dcache_rdata[0];
                    w_dc_addr_nxt  = {w_acc_addr[ADDR_W-1:1], 1'b0};
                    w_dc_read_nxt  = memop_is_load(w_acc_op);
                    w_dc_write_nxt = !memop_is_load(w_acc_op);
                    w_dc_wdata_nxt = memop_is_load(w_acc_op) ? '0 : w_st_wdata;
                    w_dc_be_nxt    = w_st_be;
                end
            end

            S_DATA: begin
                w_stall = 1'b1;
                if (dcache_resp) begin
                    w_state_nxt    = S_DONE;
                    w_dc_read_nxt  = 1'b0;
                    w_dc_write_nxt = 1'b0;
                    w_dc_be_nxt    = 2'b00;
                    w_rdata_nxt    = memop_is_load(r_op) ? w_ld_result : '0;
                end
            end

            S_DONE: begin
                // Single completion cycle lets EX/MEM advance exactly once
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any outstanding access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_op       <= LD;
            r_addr_lsb <= 1'b0;
            r_wdata    <= '0;
            r_dc_addr  <= '0;
            r_dc_read  <= 1'b0;
            r_dc_write <= 1'b0;
            r_dc_wdata <= '0;
            r_dc_be    <= 2'b00;
            r_rdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_addr_lsb <= w_addr_lsb_nxt;
            r_wdata    <= w_wdata_nxt;
            r_dc_addr  <= w_dc_addr_nxt;
            r_dc_read  <= w_dc_read_nxt;
            r_dc_write <= w_dc_write_nxt;
            r_dc_wdata <= w_dc_wdata_nxt;
            r_dc_be    <= w_dc_be_nxt;
            r_rdata    <= w_rdata_nxt;
        end
    end

    assign dcache_address     = r_dc_addr;
    assign dcache_read        = r_dc_read;
    assign dcache_write       = r_dc_write;
    assign dcache_wdata       = r_dc_wdata;
    assign dcache_byte_enable = r_dc_be;
    assign rdata_out          = r_rdata;
    // A pending req_valid must not raise stall while reset is asserted
    assign stall              = w_stall && reset_n;
    assign done               = w_done;

endmodule : mem_stage_access_ctrl
`default_nettype wire
